// File: rtl/fs_serial_nbit.sv
// ----------------------------------------------------------------------------
// fs_serial_nbit
//   Multi-cycle N-bit subtractor computing D = A - B - BIN, DIGIT bits per
//   clock. Each clock pushes one slice through a ripple of DIGIT full-subtractor
//   cells. The borrow is held in a register between slices. The design reports
//   borrow-out and two's-complement overflow.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits processed per clock (WIDTH % DIGIT == 0)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while busy == 0
//   clr    in   synchronous abort back to IDLE (no done pulse)
//   a      in   minuend, captured on an accepted start
//   b      in   subtrahend, captured on an accepted start
//   bin    in   borrow-in, captured on an accepted start
//   busy   out  operation in progress
//   done   out  one-cycle pulse: diff/bout/ovf updated
//   diff   out  (A - B - BIN) mod 2^WIDTH, held until the next done
//   bout   out  borrow out of the MSB (A < B + BIN, unsigned)
//   ovf    out  signed overflow = borrow into MSB XOR borrow out of MSB
//
// Handshake: a request is accepted on any rising edge where start == 1,
// busy == 0 and clr == 0. No request is queued while busy == 1. done is high
// for exactly one cycle, STEPS edges after acceptance, and busy is low in that
// cycle. A start held high in the done cycle is therefore accepted back-to-back.
// ----------------------------------------------------------------------------
module fs_serial_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("fs_serial_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow_r;
    logic [CW-1:0]    count;

    // One slice: DIGIT full-subtractor cells rippling LSB -> MSB.
    // chain[i] is the borrow into cell i; chain[DIGIT] leaves the slice.
    logic [DIGIT-1:0] slice_d;
    logic [DIGIT:0]   chain;

    always_comb begin
        slice_d  = '0;
        chain    = '0;
        chain[0] = borrow_r;
        for (int i = 0; i < DIGIT; i++) begin
            slice_d[i]   = a_sr[i] ^ b_sr[i] ^ chain[i];
            chain[i+1]   = (~a_sr[i] & b_sr[i]) | (~a_sr[i] & chain[i]) | (b_sr[i] & chain[i]);
        end
    end

    // New slice bits enter the result register from the top. After STEPS
    // slices, the first slice has reached the bottom. The concatenation also
    // covers DIGIT == WIDTH without a reversed part-select.
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;

    assign res_cat  = {slice_d, res_sr};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_r <= 1'b0;
            count    <= '0;
        end else if (clr) begin
            // Abort: the result outputs keep their last completed values.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow_r <= bin;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> DIGIT;
                    b_sr     <= b_sr >> DIGIT;
                    res_sr   <= res_next;
                    borrow_r <= chain[DIGIT];
                    count    <= count + 1'b1;
                    if (count == LAST) begin
                        // The last slice holds the MSB in cell DIGIT-1, so
                        // chain[DIGIT-1] is the borrow into the MSB.
                        diff  <= res_next;
                        bout  <= chain[DIGIT];
                        ovf   <= chain[DIGIT-1] ^ chain[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fs_serial_nbit.sv
// ----------------------------------------------------------------------------
// tb_fs_serial_nbit
//   Bench for fs_serial_nbit. It drives five instances:
//     idx 0: W=8 D=1   idx 1: W=8 D=4   idx 2: W=4 D=1   idx 3: W=4 D=2
//     idx 4: W=4 D=4
//   Expected results come from signed/unsigned integer arithmetic.
// ----------------------------------------------------------------------------
module tb_fs_serial_nbit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    always #5 clk = ~clk;

    // ---------------- per-instance stimulus and outputs ----------------
    logic [4:0] start_v;
    logic [7:0] a_v [5];
    logic [7:0] b_v [5];
    logic [4:0] bin_v;
    wire  [4:0] busy_v;
    wire  [4:0] done_v;
    wire  [4:0] bout_v;
    wire  [4:0] ovf_v;
    wire  [7:0] d0, d1;
    wire  [3:0] d2, d3, d4;
    logic [7:0] diff_v [5];

    assign diff_v[0] = d0;
    assign diff_v[1] = d1;
    assign diff_v[2] = {4'b0, d2};
    assign diff_v[3] = {4'b0, d3};
    assign diff_v[4] = {4'b0, d4};

    fs_serial_nbit #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .clr(clr),
        .a(a_v[0]), .b(b_v[0]), .bin(bin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .diff(d0), .bout(bout_v[0]), .ovf(ovf_v[0]));

    fs_serial_nbit #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .clr(clr),
        .a(a_v[1]), .b(b_v[1]), .bin(bin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .diff(d1), .bout(bout_v[1]), .ovf(ovf_v[1]));

    fs_serial_nbit #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .clr(clr),
        .a(a_v[2][3:0]), .b(b_v[2][3:0]), .bin(bin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .diff(d2), .bout(bout_v[2]), .ovf(ovf_v[2]));

    fs_serial_nbit #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .clr(clr),
        .a(a_v[3][3:0]), .b(b_v[3][3:0]), .bin(bin_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .diff(d3), .bout(bout_v[3]), .ovf(ovf_v[3]));

    fs_serial_nbit #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[4]), .clr(clr),
        .a(a_v[4][3:0]), .b(b_v[4][3:0]), .bin(bin_v[4]),
        .busy(busy_v[4]), .done(done_v[4]), .diff(d4), .bout(bout_v[4]), .ovf(ovf_v[4]));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];   // expected diff of the last completed op, idx 0

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int w_of(input int idx);
        return (idx < 2) ? 8 : 4;
    endfunction

    function automatic int steps_of(input int idx);
        case (idx)
            0:       return 8;
            1:       return 2;
            2:       return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    // Reference model: uses plain integer arithmetic on the operand values.
    function automatic void model(input int w, input int av, input int bv, input int bi,
                                  output logic [7:0] d, output logic bo, output logic ov);
        int m;
        int r;
        int sa;
        int sb;
        int s;
        m  = 1 << w;
        r  = av - bv - bi;
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        s  = sa - sb - bi;
        d  = 8'((r + m) % m);
        bo = (r < 0);
        ov = (s < -(m / 2)) || (s >= m / 2);
    endfunction

    // ---------------- driver tasks ----------------
    // Wait at most 40 edges for done; cyc returns the edge count (41 on timeout).
    task automatic wait_done(input int idx, output int cyc);
        cyc = 0;
        while (done_v[idx] !== 1'b1 && cyc <= 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_result(input int idx, input logic [7:0] av, input logic [7:0] bv,
                                input logic bi);
        logic [7:0] ed;
        logic       eb;
        logic       eo;
        model(w_of(idx), int'(av), int'(bv), int'(bi), ed, eb, eo);
        check($sformatf("diff[%0d] %0h-%0h-%0d", idx, av, bv, bi), 32'(diff_v[idx]), 32'(ed));
        check($sformatf("bout[%0d] %0h-%0h-%0d", idx, av, bv, bi), 32'(bout_v[idx]), 32'(eb));
        check($sformatf("ovf[%0d] %0h-%0h-%0d", idx, av, bv, bi), 32'(ovf_v[idx]), 32'(eo));
        check($sformatf("busy_at_done[%0d]", idx), 32'(busy_v[idx]), 32'd0);
        if (idx == 0) begin
            exp_q.delete();
            exp_q.push_back(ed);
        end
    endtask

    // Called #1 after a rising edge. Returns #1 after the done edge.
    task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi);
        int cyc;
        a_v[idx]     = av;
        b_v[idx]     = bv;
        bin_v[idx]   = bi;
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        // Scrambling the inputs after acceptance must not affect the result.
        a_v[idx]     = 8'($urandom);
        b_v[idx]     = 8'($urandom);
        bin_v[idx]   = 1'($urandom);
        check($sformatf("busy_after_start[%0d]", idx), 32'(busy_v[idx]), 32'd1);
        wait_done(idx, cyc);
        check($sformatf("latency[%0d]", idx), 32'(cyc), 32'(steps_of(idx)));
        check_result(idx, av, bv, bi);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int pulses;
        logic [7:0] seen_diff;

        rst_n   = 1'b0;
        clr     = 1'b0;
        start_v = '0;
        bin_v   = '0;
        for (int i = 0; i < 5; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst_done[%0d]", i), 32'(done_v[i]), 32'd0);
            check($sformatf("rst_diff[%0d]", i), 32'(diff_v[i]), 32'd0);
            check($sformatf("rst_bout[%0d]", i), 32'(bout_v[i]), 32'd0);
            check($sformatf("rst_ovf[%0d]", i), 32'(ovf_v[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed W=8 D=1 cases.
        run_op(0, 8'h35, 8'h12, 1'b0);
        check("t1_diff_const", 32'(diff_v[0]), 32'h23);
        run_op(0, 8'h00, 8'h01, 1'b0);
        check("t2_bout_const", 32'(bout_v[0]), 32'd1);
        run_op(0, 8'h80, 8'h01, 1'b0);
        check("t2_ovf_const", 32'(ovf_v[0]), 32'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done_v[0]), 32'd0);

        // W=8 D=4 with start held high: the second request is accepted in the done cycle.
        a_v[1] = 8'h10; b_v[1] = 8'h0F; bin_v[1] = 1'b1; start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        wait_done(1, cyc);
        check("b2b_latency1", 32'(cyc), 32'd2);
        check_result(1, 8'h10, 8'h0F, 1'b1);
        a_v[1] = 8'h05; b_v[1] = 8'h07; bin_v[1] = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_busy", 32'(busy_v[1]), 32'd1);
        check("b2b_done_low", 32'(done_v[1]), 32'd0);
        start_v[1] = 1'b0;
        wait_done(1, cyc);
        check("b2b_latency2", 32'(cyc), 32'd2);
        check_result(1, 8'h05, 8'h07, 1'b0);
        @(posedge clk);
        #1;

        // A start during RUN is ignored: one done pulse carrying the first result.
        a_v[0] = 8'h35; b_v[0] = 8'h12; bin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        pulses = 0;
        seen_diff = 8'h00;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                start_v[0] = 1'b1; a_v[0] = 8'hFF; b_v[0] = 8'h00; bin_v[0] = 1'b1;
            end
            if (c == 4) start_v[0] = 1'b0;
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                pulses++;
                seen_diff = diff_v[0];
            end
        end
        check("ignore_pulses", 32'(pulses), 32'd1);
        check("ignore_diff", 32'(seen_diff), 32'h23);
        exp_q.delete();
        exp_q.push_back(8'h23);

        // An abort in RUN ends the operation with no done, and diff is kept.
        a_v[0] = 8'h11; b_v[0] = 8'h22; bin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_busy", 32'(busy_v[0]), 32'd0);
        check("clr_done", 32'(done_v[0]), 32'd0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) pulses++;
        end
        check("clr_no_done", 32'(pulses), 32'd0);
        check("clr_diff_kept", 32'(diff_v[0]), 32'(exp_q[0]));

        // An asynchronous reset in RUN clears the outputs at once.
        run_op(0, 8'h00, 8'h01, 1'b0);
        a_v[0] = 8'hAA; b_v[0] = 8'h11; bin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_v[0]), 32'd0);
        check("arst_done", 32'(done_v[0]), 32'd0);
        check("arst_diff", 32'(diff_v[0]), 32'd0);
        check("arst_bout", 32'(bout_v[0]), 32'd0);
        check("arst_ovf", 32'(ovf_v[0]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random operations on the W=8 instances.
        for (int n = 0; n < 150; n++) begin
            run_op(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
            run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
        end

        // Exhaustive test of each W=4 instance.
        for (int idx = 2; idx < 5; idx++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    for (int bi = 0; bi < 2; bi++) begin
                        run_op(idx, 8'(av), 8'(bv), 1'(bi));
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
